// File: rtl/axi_stream_writer_fifo.sv
// axi_stream_writer_fifo
// User-side write port feeding a first-word fall-through FIFO that drives an
// AXI4-Stream master. The head entry is shown combinationally on M_AXIS_*.
// A beat written into an empty FIFO appears one cycle after the write edge.
//
// Optional feature (macro STREAMIF_AUTO_TLAST_EN):
//   When defined, output beats accepted in the current packet are counted.
//   TLAST is forced on the beat that would make the packet C_MAX_PKT_LEN long.
//   When undefined, TLAST is the stored user last bit only.
module axi_stream_writer_fifo #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_FIFO_DEPTH_LOG2    = 4,
  parameter int C_MAX_PKT_LEN        = 256
) (
  input  logic                                M_AXIS_ACLK,
  input  logic                                M_AXIS_ARESETN,
  // user write side
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     data,
  input  logic                                data_valid,
  input  logic                                data_last,
  output logic                                ready,
  output logic [C_FIFO_DEPTH_LOG2:0]          level,
  // AXI4-Stream master
  output logic                                M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY
);

  localparam int DW    = C_M_AXIS_TDATA_WIDTH;
  localparam int AW    = C_FIFO_DEPTH_LOG2;
  localparam int LW    = C_FIFO_DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << C_FIFO_DEPTH_LOG2;

  // Storage holds {last, data}; it is never reset, occupancy tracks validity.
  logic [DW:0]    mem [DEPTH];

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q,  level_d;

  logic           full;
  logic           empty;
  logic           wr_en;
  logic           rd_en;
  logic [DW:0]    head;
  logic           stored_last;
  logic           force_last;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

  // Ready is gated by reset so it drops immediately while reset is held and
  // rises in the first cycle after release.
  assign ready = M_AXIS_ARESETN && !full;
  assign level = level_q;

  // A full FIFO never accepts, even if the head is popped in the same cycle.
  assign wr_en = data_valid && ready;
  assign rd_en = M_AXIS_TVALID && M_AXIS_TREADY;

  assign head        = mem[rd_ptr_q];
  assign stored_last = head[DW];

  assign M_AXIS_TVALID = !empty;
  assign M_AXIS_TDATA  = head[DW-1:0];
  assign M_AXIS_TSTRB  = '1;
  // TLAST is held low while empty so stale storage never leaks out.
  assign M_AXIS_TLAST  = !empty && (stored_last || force_last);

`ifdef STREAMIF_AUTO_TLAST_EN
  localparam int CW = (C_MAX_PKT_LEN > 2) ? $clog2(C_MAX_PKT_LEN) : 1;

  logic [CW-1:0]  beat_cnt_q, beat_cnt_d;

  assign force_last = (beat_cnt_q == CW'(C_MAX_PKT_LEN - 1));

  // Beat counter: clears on any accepted last beat, else counts accepted beats.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (rd_en) begin
      if (M_AXIS_TLAST) begin
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + CW'(1);
      end
    end
  end

  // Beat counter register, cleared by reset.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end
`else
  assign force_last = 1'b0;
`endif

  // Next-state for pointers and occupancy; pointers wrap naturally at AW bits.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state: reset discards every buffered beat, including the head.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // FIFO storage write; no reset so it maps onto plain memory.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= {data_last, data};
    end
  end

endmodule

// File: tb/tb_axi_stream_writer_fifo.sv
// Directed bench for axi_stream_writer_fifo (32-bit data, 16-entry FIFO).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_axi_stream_writer_fifo;

  localparam int W     = 32;
  localparam int LOG2  = 4;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [W-1:0]     data;
  logic             data_valid;
  logic             data_last;
  logic             ready;
  logic [LOG2:0]    level;
  logic             tvalid;
  logic [W-1:0]     tdata;
  logic [W/8-1:0]   tstrb;
  logic             tlast;
  logic             tready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_stream_writer_fifo #(
    .C_M_AXIS_TDATA_WIDTH (W),
    .C_FIFO_DEPTH_LOG2    (LOG2),
    .C_MAX_PKT_LEN        (4)
  ) dut (
    .M_AXIS_ACLK    (clk),
    .M_AXIS_ARESETN (rst_n),
    .data           (data),
    .data_valid     (data_valid),
    .data_last      (data_last),
    .ready          (ready),
    .level          (level),
    .M_AXIS_TVALID  (tvalid),
    .M_AXIS_TDATA   (tdata),
    .M_AXIS_TSTRB   (tstrb),
    .M_AXIS_TLAST   (tlast),
    .M_AXIS_TREADY  (tready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected TLAST for output beat i of a packet whose user last is at last_idx
  // (-1 if none). Auto mode is built with a 4-beat packet limit.
  function automatic logic exp_tlast(input int i, input int last_idx);
`ifdef STREAMIF_AUTO_TLAST_EN
    return (i % 4 == 3) || (i == last_idx);
`else
    return (i == last_idx);
`endif
  endfunction

  initial begin
    int in_i;
    int out_i;
    int cyc;
    logic acc;
    logic prev_stall;
    logic [W-1:0] pd;
    logic pl;

    rst_n      = 1'b0;
    data       = '0;
    data_valid = 1'b0;
    data_last  = 1'b0;
    tready     = 1'b0;
    step();
    step();

    // Reset state
    check("rst_tvalid", tvalid, 0);
    check("rst_level",  level,  0);
    check("rst_ready",  ready,  0);
    check("rst_tlast",  tlast,  0);
    check("tstrb_ones", tstrb,  4'hF);

    rst_n = 1'b1;
    #1;
    check("release_ready", ready, 1);

    // Single-beat packet, fall-through latency of one cycle
    tready     = 1'b1;
    data       = 32'hA5A5_0001;
    data_last  = 1'b1;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    data_last  = 1'b0;
    check("one_tvalid", tvalid, 1);
    check("one_tdata",  tdata,  32'hA5A5_0001);
    check("one_tlast",  tlast,  1);
    check("one_level",  level,  1);
    step();
    check("one_level_after", level,  0);
    check("one_tvalid_after", tvalid, 0);
    check("one_tlast_empty", tlast, 0);

    // Fill to full with the sink stalled, then an overflow attempt
    tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      data       = W'(i);
      data_valid = 1'b1;
      step();
    end
    check("full_ready", ready, 0);
    check("full_level", level, 16);
    data = 32'h0000_0099;
    step();
    check("ovf_level", level, 16);
    check("ovf_head",  tdata, 0);
    data_valid = 1'b0;
    tready     = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_tvalid", tvalid, 1);
      check("drain_tdata",  tdata,  W'(i));
      check("drain_tlast",  tlast,  exp_tlast(i, -1));
      step();
    end
    check("drain_level",  level,  0);
    check("drain_ready",  ready,  1);
    check("drain_tvalid_end", tvalid, 0);

    // Simultaneous write and read hold occupancy steady
    tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data       = W'(100 + i);
      data_valid = 1'b1;
      step();
    end
    check("sim_level_pre", level, 5);
    tready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      data       = W'(105 + c);
      data_last  = (c == 9);
      data_valid = 1'b1;
      check("sim_tdata", tdata, W'(100 + c));
      check("sim_tlast", tlast, exp_tlast(c, 14));
      step();
      check("sim_level", level, 5);
    end
    data_valid = 1'b0;
    data_last  = 1'b0;
    for (int c = 10; c < 15; c++) begin
      check("sim_tail_tdata", tdata, W'(100 + c));
      check("sim_tail_tlast", tlast, exp_tlast(c, 14));
      step();
    end
    check("sim_level_end", level, 0);

    // 40-beat packet with a randomly stalling sink
    in_i       = 0;
    out_i      = 0;
    cyc        = 0;
    prev_stall = 1'b0;
    pd         = '0;
    pl         = 1'b0;
    while (out_i < 40 && cyc < 400) begin
      tready = 1'($urandom_range(0, 1));
      if (in_i < 40 && ready) begin
        data_valid = 1'b1;
        data       = W'(2000 + in_i);
        data_last  = (in_i == 39);
      end else begin
        data_valid = 1'b0;
        data_last  = 1'b0;
      end
      if (tvalid && tready) begin
        check("pkt_tdata", tdata, W'(2000 + out_i));
        check("pkt_tlast", tlast, exp_tlast(out_i, 39));
        $display("pkt beat %0d tdata=0x%0h tlast=%0d", out_i, tdata, tlast);
        out_i++;
      end
      prev_stall = tvalid && !tready;
      pd         = tdata;
      pl         = tlast;
      acc        = data_valid && ready;
      step();
      cyc++;
      if (acc) in_i++;
      if (prev_stall) begin
        check("stall_tvalid", tvalid, 1);
        check("stall_tdata",  tdata,  pd);
        check("stall_tlast",  tlast,  pl);
      end
    end
    data_valid = 1'b0;
    data_last  = 1'b0;
    check("pkt_done", out_i, 40);

    // 10-beat packet, user last only on beat 9
    tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      data       = W'(3000 + i);
      data_last  = (i == 9);
      data_valid = 1'b1;
      step();
    end
    data_valid = 1'b0;
    data_last  = 1'b0;
    tready     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("p10_tdata", tdata, W'(3000 + i));
      check("p10_tlast", tlast, exp_tlast(i, 9));
      step();
    end
    check("p10_level", level, 0);

    // Reset mid-stream discards buffered beats
    tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      data       = W'(4000 + i);
      data_valid = 1'b1;
      step();
    end
    data_valid = 1'b0;
    check("pre_rst_level", level, 8);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", tvalid, 0);
    check("mid_rst_level",  level,  0);
    check("mid_rst_ready",  ready,  0);
    check("mid_rst_tlast",  tlast,  0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", ready, 1);
    tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_tvalid", tvalid, 0);
      check("post_rst_level",  level,  0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_stream_writer_fifo.md
AXI_STREAM_WRITER_FIFO -- requirements
Module: axi_stream_writer_fifo

Interface
REQ-001 SHALL have parameter C_M_AXIS_TDATA_WIDTH, default 32, stream data width in bits (multiple of 8).
REQ-002 SHALL have parameter C_FIFO_DEPTH_LOG2, default 4, FIFO depth = 2**C_FIFO_DEPTH_LOG2 entries (min 1).
REQ-003 SHALL have parameter C_MAX_PKT_LEN, default 256, max beats per packet (used only with the REQ-026 macro, min 2).
REQ-004 SHALL have port M_AXIS_ACLK  input  1  sole clock, rising edge.
REQ-005 SHALL have port M_AXIS_ARESETN  input  1  asynchronous active-low reset.
REQ-006 SHALL have port data  input  C_M_AXIS_TDATA_WIDTH  user write data.
REQ-007 SHALL have port data_valid  input  1  user write request.
REQ-008 SHALL have port data_last  input  1  user marks final beat of packet.
REQ-009 SHALL have port ready  output  1  FIFO can accept a beat this cycle.
REQ-010 SHALL have port level  output  C_FIFO_DEPTH_LOG2+1  current FIFO occupancy.
REQ-011 SHALL have ports M_AXIS_TVALID out 1, M_AXIS_TDATA out C_M_AXIS_TDATA_WIDTH, M_AXIS_TSTRB out C_M_AXIS_TDATA_WIDTH/8, M_AXIS_TLAST out 1, M_AXIS_TREADY in 1: AXI4-Stream master.

Function
REQ-012 SHALL store {data_last, data} into the FIFO on a rising edge where data_valid && ready (write).
REQ-013 SHALL drive ready = 1 when level < depth and reset deasserted, else 0; no write accepted when full, even if a read occurs in the same cycle.
REQ-014 SHALL present the FIFO head combinationally (first-word fall-through): M_AXIS_TVALID = (level != 0).
REQ-015 SHALL pop the head on a rising edge where M_AXIS_TVALID && M_AXIS_TREADY (read).
REQ-016 SHALL show a beat written into an empty FIFO on M_AXIS_TVALID exactly 1 cycle after the write edge; no combinational bypass from data to M_AXIS_TDATA.
REQ-017 SHALL keep M_AXIS_TDATA/M_AXIS_TLAST stable while M_AXIS_TVALID && !M_AXIS_TREADY; M_AXIS_TVALID SHALL not drop without a read.
REQ-018 SHALL update level: +1 on write only, -1 on read only, unchanged on simultaneous write and read (possible only when 0 < level < depth).
REQ-019 SHALL use wrap-around read/write pointers of C_FIFO_DEPTH_LOG2 bits, full/empty derived from level.
REQ-020 SHALL drive M_AXIS_TSTRB to all ones constantly.
REQ-021 SHALL drive M_AXIS_TLAST from the stored last bit of the head entry (subject to REQ-026).
REQ-022 SHALL ignore data/data_last/data_valid when ready = 0; no state change, no error flag.

Reset
REQ-023 SHALL on M_AXIS_ARESETN low, asynchronously: pointers = 0, level = 0, M_AXIS_TVALID = 0, ready = 0, beat counter (if present) = 0; M_AXIS_TLAST = 0 while empty.
REQ-024 SHALL discard all buffered beats when reset asserts mid-packet, including a pending unaccepted head beat.
REQ-025 SHALL assert ready = 1 in the first cycle after reset release; FIFO storage itself need not be reset.

Configuration
REQ-026 SHALL, when STREAMIF_AUTO_TLAST_EN is defined, count output beats accepted in the current packet (counter width clog2(C_MAX_PKT_LEN)) and force M_AXIS_TLAST = 1 when count == C_MAX_PKT_LEN-1 or the stored last bit is 1; the counter clears on any read with M_AXIS_TLAST = 1, else increments on each read.
REQ-027 SHALL, when STREAMIF_AUTO_TLAST_EN is undefined, contain no beat counter and M_AXIS_TLAST = stored last bit only; packets of any length pass unsplit.

Verification
REQ-028 Reset release, write 0xA5A5_0001 with data_last=1, TREADY=1 -> TVALID=1 with TDATA=0xA5A5_0001, TLAST=1 one cycle after write; level 1->0 after read.
REQ-029 TREADY=0, write 16 beats 0..15 -> ready=0 after 16th write, level=16, 17th beat dropped; then TREADY=1 -> beats 0..15 out in order, level 0, ready=1.
REQ-030 level=5, data_valid=1 and TREADY=1 for 10 cycles -> level stays 5, output order matches input order.
REQ-031 TREADY toggled 1/0 pseudo-randomly during 40-beat packet -> TDATA/TLAST stable whenever TVALID && !TREADY, TLAST only on beat 39.
REQ-032 Write 8 beats, TREADY=0, assert ARESETN low mid-stream -> TVALID=0, level=0, ready=0 immediately; after release, no stale beat appears.
REQ-033 STREAMIF_AUTO_TLAST_EN, C_MAX_PKT_LEN=4, 10 beats with data_last only on beat 9 -> TLAST on beats 3, 7, 9; counter zero after beat 9.
